// File: rtl/mem_arb_pkg.sv
// Shared constants for the data-memory/MMIO arbiter: FSM encodings and the slave address map.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [31:0] DMEM_BASE = 32'h0000_0000;
    localparam logic [31:0] DMEM_SIZE = 32'h0000_1000;
    localparam logic [31:0] UART_ADDR = 32'h4000_0000;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first requesting index after ptr, wrapping at N_MASTERS.
module rr_picker #(
    parameter int N_MASTERS = 2,
    parameter int IDX_W     = 1
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic                 gnt_valid,
    output logic [IDX_W-1:0]     gnt_idx
);

    // NOTE: every output gets a default before the loops so no latch is inferred.
    // Two descending passes: lowest index at or below ptr (wrap case), then lowest above ptr overrides.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (req[i] && (IDX_W'(i) <= ptr)) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(i);
            end
        end
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (req[i] && (IDX_W'(i) > ptr)) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one DMEM/UART slave port between N load/store units.
// Optional bus-lock re-grant for atomic sequences is enabled by defining MEM_ARB_LOCK_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int IDX_W     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_MASTERS-1:0]      m_req,
    input  logic [N_MASTERS-1:0]      m_we,
    input  logic [32*N_MASTERS-1:0]   m_addr,
    input  logic [32*N_MASTERS-1:0]   m_wdata,
    input  logic [N_MASTERS-1:0]      m_lock,
    output logic [N_MASTERS-1:0]      m_ack,
    output logic [31:0]               m_rdata,
    output logic                      s_req,
    output logic                      s_we,
    output logic [31:0]               s_addr,
    output logic [31:0]               s_wdata,
    input  logic [31:0]               s_rdata,
    input  logic                      s_ready
);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_ptr;
    logic             r_s_req;
    logic             r_s_we;
    logic [31:0]      r_s_addr;
    logic [31:0]      r_s_wdata;
    logic [31:0]      r_m_rdata;

    logic             w_pick_valid;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_win_valid;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_sel_we;
    logic [31:0]      w_sel_addr;
    logic [31:0]      w_sel_wdata;

    rr_picker #(
        .N_MASTERS (N_MASTERS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req       (m_req),
        .ptr       (r_ptr),
        .gnt_valid (w_pick_valid),
        .gnt_idx   (w_pick_idx)
    );

`ifdef MEM_ARB_LOCK_EN
    logic r_lock_hold;
    logic w_owner_req;
    logic w_owner_lock;

    always_comb begin
        w_owner_req  = 1'b0;
        w_owner_lock = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (r_owner == IDX_W'(i)) begin
                w_owner_req  = m_req[i];
                w_owner_lock = m_lock[i];
            end
        end
    end

    // Lock is sampled in RESP and consumed by the very next IDLE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_hold <= 1'b0;
        end else if (r_state == ST_RESP) begin
            r_lock_hold <= w_owner_lock;
        end else if (r_state == ST_IDLE) begin
            r_lock_hold <= 1'b0;
        end
    end

    assign w_win_valid = (r_lock_hold && w_owner_req) || w_pick_valid;
    assign w_win_idx   = (r_lock_hold && w_owner_req) ? r_owner : w_pick_idx;
`else
    logic w_unused_lock;
    assign w_unused_lock = ^m_lock;
    assign w_win_valid   = w_pick_valid;
    assign w_win_idx     = w_pick_idx;
`endif

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (w_win_idx == IDX_W'(i)) begin
                w_sel_we    = m_we[i];
                w_sel_addr  = m_addr[32*i +: 32];
                w_sel_wdata = m_wdata[32*i +: 32];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_owner   <= '0;
            r_ptr     <= IDX_W'(N_MASTERS - 1);
            r_s_req   <= 1'b0;
            r_s_we    <= 1'b0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_m_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_win_valid) begin
                        r_owner   <= w_win_idx;
                        r_s_we    <= w_sel_we;
                        r_s_addr  <= w_sel_addr;
                        r_s_wdata <= w_sel_wdata;
                        r_s_req   <= 1'b1;
                        r_state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (s_ready) begin
                        r_m_rdata <= s_rdata;
                        r_s_req   <= 1'b0;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_ptr   <= r_owner;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        m_ack = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            m_ack[i] = (r_state == ST_RESP) && (r_owner == IDX_W'(i));
        end
    end

    assign m_rdata = r_m_rdata;
    assign s_req   = r_s_req;
    assign s_we    = r_s_we;
    assign s_addr  = r_s_addr;
    assign s_wdata = r_s_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random traffic against a
// transaction-level reference model. Lock scenarios run when MEM_ARB_LOCK_EN is defined.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int N     = 3;
    localparam int IDX_W = 2;

    logic              clk;
    logic              rst;
    logic [N-1:0]      m_req;
    logic [N-1:0]      m_we;
    logic [32*N-1:0]   m_addr;
    logic [32*N-1:0]   m_wdata;
    logic [N-1:0]      m_lock;
    logic [N-1:0]      m_ack;
    logic [31:0]       m_rdata;
    logic              s_req;
    logic              s_we;
    logic [31:0]       s_addr;
    logic [31:0]       s_wdata;
    logic [31:0]       s_rdata;
    logic              s_ready;

    mem_arbiter #(
        .N_MASTERS (N),
        .IDX_W     (IDX_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_lock  (m_lock),
        .m_ack   (m_ack),
        .m_rdata (m_rdata),
        .s_req   (s_req),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_ready (s_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: transaction progress (0 waiting, 1 slave access open, 2 ack due).
    int          md_phase;
    int          md_owner;
    int          md_ptr;
    bit          md_lock_hold;
    logic        md_we;
    logic [31:0] md_addr;
    logic [31:0] md_wdata;
    logic [31:0] md_rdata;

    // Fairness bookkeeping derived from observed grants/acks.
    int          wait_cnt [N];
    logic [N-1:0] prev_req;
    logic [N-1:0] grant_snap;
    logic        prev_sreq;

    function automatic int rr_next(input int ptr, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        if (rst) begin
            md_phase     = 0;
            md_ptr       = N - 1;
            md_owner     = 0;
            md_lock_hold = 1'b0;
            md_we        = 1'b0;
            md_addr      = '0;
            md_wdata     = '0;
            md_rdata     = '0;
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
            grant_snap = '0;
            return;
        end
        case (md_phase)
            0: begin
                int w;
                w = -1;
`ifdef MEM_ARB_LOCK_EN
                if (md_lock_hold && m_req[md_owner]) w = md_owner;
`endif
                if (w < 0) w = rr_next(md_ptr, m_req);
                md_lock_hold = 1'b0;
                if (w >= 0) begin
                    md_owner = w;
                    md_we    = m_we[w];
                    md_addr  = m_addr[32*w +: 32];
                    md_wdata = m_wdata[32*w +: 32];
                    md_phase = 1;
                end
            end
            1: begin
                if (s_ready) begin
                    md_rdata = s_rdata;
                    md_phase = 2;
                end
            end
            default: begin
                md_ptr = md_owner;
`ifdef MEM_ARB_LOCK_EN
                md_lock_hold = m_lock[md_owner];
`endif
                md_phase = 0;
            end
        endcase
    endtask

    task automatic check_model();
        logic [31:0] exp_ack;
        exp_ack = (md_phase == 2) ? (32'd1 << md_owner) : 32'd0;
        chk("s_req", {31'd0, s_req}, {31'd0, md_phase == 1});
        chk("m_ack", {29'd0, m_ack}, exp_ack);
        chk("m_rdata", m_rdata, md_rdata);
        if (md_phase == 1) begin
            chk("s_addr", s_addr, md_addr);
            chk("s_we", {31'd0, s_we}, {31'd0, md_we});
            chk("s_wdata", s_wdata, md_wdata);
        end
    endtask

    task automatic track_fairness();
        if (s_req === 1'b1 && prev_sreq !== 1'b1) grant_snap = prev_req;
        for (int j = 0; j < N; j++) begin
            if (m_ack[j] === 1'b1) begin
                for (int i = 0; i < N; i++) begin
                    if (i != j && grant_snap[i]) wait_cnt[i]++;
                end
`ifndef MEM_ARB_LOCK_EN
                chk($sformatf("starve_m%0d", j), {31'd0, wait_cnt[j] <= N - 1}, 32'd1);
`endif
                wait_cnt[j] = 0;
            end
        end
    endtask

    // One clock cycle: inputs already set by the caller at the current negedge.
    task automatic run_cycle();
        check_model();
        track_fairness();
        model_step();
        prev_req  = m_req;
        prev_sreq = s_req;
        @(negedge clk);
    endtask

    task automatic reset_cycles(input int n);
        rst = 1'b1;
        repeat (n) begin
            model_step();
            @(negedge clk);
        end
        rst       = 1'b0;
        prev_req  = '0;
        prev_sreq = 1'b0;
    endtask

    task automatic set_master(input int i, input logic req, input logic we,
                              input logic [31:0] addr, input logic [31:0] wdata);
        m_req[i]             = req;
        m_we[i]              = we;
        m_addr[32*i +: 32]   = addr;
        m_wdata[32*i +: 32]  = wdata;
    endtask

    initial begin
        rst     = 1'b1;
        m_req   = '0;
        m_we    = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_lock  = '0;
        s_rdata = '0;
        s_ready = 1'b0;

        // Reset state
        reset_cycles(2);
        chk("rst_s_req", {31'd0, s_req}, 32'd0);
        chk("rst_m_ack", {29'd0, m_ack}, 32'd0);
        chk("rst_m_rdata", m_rdata, 32'd0);
        chk("rst_s_we", {31'd0, s_we}, 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_s_wdata", s_wdata, 32'd0);

        // Single load with zero-wait slave
        s_ready = 1'b1;
        s_rdata = 32'hDEAD_BEEF;
        set_master(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        run_cycle();
        chk("load_s_req", {31'd0, s_req}, 32'd1);
        chk("load_s_addr", s_addr, 32'h0000_0010);
        chk("load_s_we", {31'd0, s_we}, 32'd0);
        run_cycle();
        chk("load_ack", {29'd0, m_ack}, 32'b001);
        chk("load_rdata", m_rdata, 32'hDEAD_BEEF);
        m_req[0] = 1'b0;
        run_cycle();
        chk("load_ack_once", {29'd0, m_ack}, 32'd0);
        run_cycle();

        // Contention from reset: m0 and m1 alternate, one ack every 3 cycles
        reset_cycles(1);
        set_master(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        set_master(1, 1'b1, 1'b1, 32'h0000_0200, 32'hA5A5_0001);
        for (int c = 0; c < 12; c++) begin
            if (c % 3 == 2)
                chk($sformatf("cont_ack_c%0d", c), {29'd0, m_ack}, ((c / 3) % 2 == 0) ? 32'b001 : 32'b010);
            else
                chk($sformatf("cont_ack_c%0d", c), {29'd0, m_ack}, 32'd0);
            s_rdata = $urandom;
            run_cycle();
        end
        m_req = '0;
        run_cycle();

        // Slave wait states on a UART store; master inputs change while busy
        set_master(1, 1'b1, 1'b1, UART_ADDR, 32'h0000_0055);
        s_ready = 1'b0;
        run_cycle();
        for (int b = 0; b < 5; b++) begin
            chk($sformatf("ws_s_req_b%0d", b), {31'd0, s_req}, 32'd1);
            chk($sformatf("ws_s_addr_b%0d", b), s_addr, UART_ADDR);
            chk($sformatf("ws_s_wdata_b%0d", b), s_wdata, 32'h0000_0055);
            chk($sformatf("ws_ack_b%0d", b), {29'd0, m_ack}, 32'd0);
            m_addr[63:32]  = $urandom;
            m_wdata[63:32] = $urandom;
            m_we[1]        = 1'b0;
            s_ready        = (b == 4);
            run_cycle();
        end
        chk("ws_ack", {29'd0, m_ack}, 32'b010);
        m_req[1] = 1'b0;
        s_ready  = 1'b0;
        run_cycle();
        chk("ws_ack_once", {29'd0, m_ack}, 32'd0);
        run_cycle();

        // Reset while the slave access is open aborts it; priority restarts at m0
        set_master(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
        run_cycle();
        chk("rstb_busy", {31'd0, s_req}, 32'd1);
        rst = 1'b1;
        run_cycle();
        rst       = 1'b0;
        prev_req  = '0;
        prev_sreq = 1'b0;
        chk("rstb_s_req", {31'd0, s_req}, 32'd0);
        chk("rstb_m_ack", {29'd0, m_ack}, 32'd0);
        s_ready = 1'b1;
        set_master(1, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        for (int c = 0; c < 6; c++) begin
            if (c == 2) chk("rstb_first_m0", {29'd0, m_ack}, 32'b001);
            if (c == 5) chk("rstb_then_m1", {29'd0, m_ack}, 32'b010);
            run_cycle();
        end
        m_req = '0;
        run_cycle();

        // Owner drops its request one cycle after the grant
        set_master(0, 1'b1, 1'b0, 32'h0000_0030, 32'h0);
        run_cycle();
        m_req[0] = 1'b0;
        run_cycle();
        chk("drop_ack", {29'd0, m_ack}, 32'b001);
        for (int c = 0; c < 3; c++) begin
            run_cycle();
            chk($sformatf("drop_no_ack_%0d", c), {29'd0, m_ack}, 32'd0);
        end

`ifdef MEM_ARB_LOCK_EN
        // m0 holds the bus for three accesses, then m1 follows
        reset_cycles(1);
        s_ready = 1'b1;
        set_master(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
        set_master(1, 1'b1, 1'b0, 32'h0000_0090, 32'h0);
        m_lock[0] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c == 8) m_lock[0] = 1'b0;
            if (c % 3 == 2)
                chk($sformatf("lock_ack_c%0d", c), {29'd0, m_ack}, (c <= 8) ? 32'b001 : 32'b010);
            run_cycle();
        end
        m_req  = '0;
        m_lock = '0;
        run_cycle();
`endif

        // Random traffic: masters hold requests until acked; slave latency random
        reset_cycles(2);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_ack[i] === 1'b1 || !m_req[i])
                    m_req[i] = ($urandom_range(0, 3) == 0);
                m_we[i]             = $urandom_range(0, 1);
                m_addr[32*i +: 32]  = ($urandom_range(0, 3) == 0) ? UART_ADDR
                                                                  : ($urandom & (DMEM_SIZE - 32'd4));
                m_wdata[32*i +: 32] = $urandom;
                m_lock[i]           = ($urandom_range(0, 3) == 0);
            end
            s_ready = ($urandom_range(0, 2) != 0);
            s_rdata = $urandom;
            run_cycle();
        end
        m_req = '0;
        repeat (8) run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter that shares one data-memory/MMIO port (DMEM 0x0000_0000–0x0000_0FFF, UART 0x4000_0000) between N core load/store units.
- Sits between the per-core memory stages and the single slave port that feeds dmem/uart decode.
- Serialises accesses with a req/ack handshake toward masters and a req/ready handshake toward the slave.
- Tolerates variable slave latency.

Parameters:
- N_MASTERS, 2, number of requesting cores (2..8)
- IDX_W, 1, owner index width, must be ≥ clog2(N_MASTERS)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, synchronous, active-high
- m_req  input  N_MASTERS  per-master access request, held until m_ack
- m_we  input  N_MASTERS  per-master 1=store, 0=load
- m_addr  input  32*N_MASTERS  per-master byte address, master i at [32i+31:32i]
- m_wdata  input  32*N_MASTERS  per-master store data, same packing
- m_lock  input  N_MASTERS  per-master bus-lock hint (used only with MEM_ARB_LOCK_EN)
- m_ack  output  N_MASTERS  one-cycle completion pulse, one-hot or zero
- m_rdata  output  32  load data, broadcast, valid when any m_ack bit is high
- s_req  output  1  slave request
- s_we  output  1  slave write enable
- s_addr  output  32  slave address
- s_wdata  output  32  slave write data
- s_rdata  input  32  slave read data, valid with s_ready
- s_ready  input  1  slave completion, may be tied high

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; m_ack=0; m_rdata=0; s_req=0; s_we=0; s_addr=0; s_wdata=0; last-grant pointer ptr=N_MASTERS-1, so master 0 has highest priority first. rst mid-transaction aborts it with no m_ack.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If m_req≠0, select the winner by rotating priority starting at ptr+1 mod N_MASTERS.
  - Register owner, m_we[owner], m_addr[owner] and m_wdata[owner] into s_we/s_addr/s_wdata; set s_req=1; go to BUSY.
  - If m_req=0, stay in IDLE.
- BUSY:
  - s_req/s_we/s_addr/s_wdata are held stable.
  - On s_ready=1: capture s_rdata into m_rdata, drop s_req, go to RESP.
  - Otherwise stay; there is no timeout.
- RESP:
  - m_ack[owner]=1 for exactly this cycle; m_rdata holds the captured value.
  - ptr←owner; go to IDLE.
  - m_req is not sampled in RESP.
- Latency: request seen at cycle 0 gives s_req at cycle 1. With s_ready=1 in cycle 1, m_ack pulses in cycle 2. Peak throughput is one access per 3 cycles.
- For stores, m_rdata takes s_rdata (don't-care to masters).
- A master deasserting m_req while it owns the bus: the transaction still completes and the ack pulse is still issued.
- Requests from masters other than the owner are ignored until the next IDLE.
- s_ready is ignored in IDLE and RESP.
- Simultaneous requests in IDLE: exactly one winner per the rotation; losers wait with no starvation, each waiting at most N_MASTERS-1 grants.
- Captured address/data come from the IDLE cycle; later changes on m_addr/m_wdata have no effect.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- Defined: m_lock[owner] is sampled in RESP. If it was 1 and m_req[owner]=1 in the following IDLE, the same owner is re-granted, overriding rotation. A lock chain ends when the owner drops m_lock or m_req. The rotation pointer then advances from that owner. This serves atomic read-modify-write sequences.
- Undefined: m_lock is ignored and pure round-robin applies.

Decomposition:
- Shared package/header mem_arb_pkg:
  - FSM state encodings (IDLE=2'd0, BUSY=2'd1, RESP=2'd2)
  - Address map constants DMEM_BASE=32'h0, DMEM_SIZE=32'h1000, UART_ADDR=32'h4000_0000
- Sub-module rr_picker: combinational; inputs req[N], ptr; outputs gnt_valid and gnt_idx (next set bit after ptr with wrap).

Test Plan:
- Single load: m0 requests read of 0x10, s_ready tied 1, s_rdata=0xDEADBEEF → s_req high in cycle 1 with s_addr=0x10 and s_we=0; m_ack=2'b01 in cycle 2 with m_rdata=0xDEADBEEF.
- Contention: m0 and m1 both hold requests from reset → grant order m0, m1, m0, m1; each m_ack 3 cycles apart; no missed or double ack.
- Slave wait states: m1 stores 0x55 to 0x4000_0000, s_ready low 4 cycles → s_req/s_addr/s_wdata stable for all 5 BUSY cycles; exactly one m_ack[1] after s_ready.
- Reset mid-BUSY: rst asserted while s_req=1 → next cycle s_req=0, m_ack=0, ptr=N-1; subsequent m1-only request is served normally.
- Request drop: m0 deasserts m_req one cycle after grant → transaction still completes; m_ack[0] pulses once.
- With MEM_ARB_LOCK_EN: m0 holds m_lock=1 and m_req=1 while m1 requests → m0 gets 3 consecutive grants; after m0 drops m_lock, m1 is granted next.
